// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, NOP encoding, fetch FSM states and the
// IF/ID pipeline record consumed by the decode stage.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {
        FS_BOOT,
        FS_RUN
    } fetch_state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, inst: NOP_INST, pc_plus4: '0};

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID
// outputs and perf counters. master = fetch stage, slave = its environment.
interface if_stage_if #(
    parameter int IMEM_AW = 16
);
    import cpu_pkg::*;

    logic               stall_i;
    logic               redirect_i;
    logic [WORD_W-1:0]  redirect_pc_i;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [WORD_W-1:0]  imem_rdata_i;
    logic [WORD_W-1:0]  pc_o;
    logic               id_valid_o;
    logic [WORD_W-1:0]  id_inst_o;
    logic [WORD_W-1:0]  id_pc_plus4_o;
    logic [WORD_W-1:0]  perf_fetch_o;
    logic [WORD_W-1:0]  perf_stall_o;
    logic [WORD_W-1:0]  perf_flush_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_addr_o, pc_o, id_valid_o, id_inst_o, id_pc_plus4_o,
               perf_fetch_o, perf_stall_o, perf_flush_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_addr_o, pc_o, id_valid_o, id_inst_o, id_pc_plus4_o,
               perf_fetch_o, perf_stall_o, perf_flush_o
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load; with neither asserted it holds.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, boot FSM and IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/stall/flush performance counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                IMEM_AW     = 16,
    parameter int                BOOT_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e      state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [WORD_W-1:0] pc_q, pc_d, pc_plus4;
    logic              do_redirect, do_stall, do_advance;
    if_id_t            if_id_d, if_id_q;

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pc_d        = pc_q;
        do_redirect = 1'b0;
        do_stall    = 1'b0;
        do_advance  = 1'b0;
        case (state_q)
            FS_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = FS_RUN;
                end
            end
            FS_RUN: begin
                if (bus.redirect_i) begin
                    do_redirect = 1'b1;
                    pc_d        = bus.redirect_pc_i & 32'hFFFF_FFFC;
                end else if (bus.stall_i) begin
                    do_stall = 1'b1;
                end else begin
                    do_advance = 1'b1;
                    pc_d       = pc_plus4;
                end
            end
            default: state_d = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
        end
    end

    assign if_id_d = '{valid: 1'b1, inst: bus.imem_rdata_i, pc_plus4: pc_plus4};

    if_id_reg u_if_id_reg (
        .clk  (clk),
        .rst  (rst),
        .flush(do_redirect),
        .load (do_advance),
        .d    (if_id_d),
        .q    (if_id_q)
    );

    assign bus.imem_addr_o   = pc_q[IMEM_AW+1:2];
    assign bus.pc_o          = pc_q;
    assign bus.id_valid_o    = if_id_q.valid;
    assign bus.id_inst_o     = if_id_q.inst;
    assign bus.id_pc_plus4_o = if_id_q.pc_plus4;

`ifdef IF_PERF_CNT_EN
    logic [WORD_W-1:0] perf_fetch_q, perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (do_advance)  perf_fetch_q <= perf_fetch_q + 32'd1;
            if (do_stall)    perf_stall_q <= perf_stall_q + 32'd1;
            if (do_redirect) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign bus.perf_fetch_o = perf_fetch_q;
    assign bus.perf_stall_o = perf_stall_q;
    assign bus.perf_flush_o = perf_flush_q;
`else
    assign bus.perf_fetch_o = '0;
    assign bus.perf_stall_o = '0;
    assign bus.perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall, redirect, stall+redirect, address
// wrap and mid-stall reset, against hand-computed PC/IF-ID values.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    if_stage_if #(.IMEM_AW(16)) bus ();

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_AW    (16),
        .BOOT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory contents: word 0 is the first real instruction,
    // word 5 is an all-zero NOP, all others encode their own address.
    function automatic logic [31:0] imem_model(input logic [15:0] a);
        if (a == 16'd0) return 32'h0020_1820;
        if (a == 16'd5) return 32'h0000_0000;
        return {16'h8C00, a};
    endfunction

    assign bus.imem_rdata_i = imem_model(bus.imem_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] pc, input logic valid,
                             input logic [31:0] inst, input logic [31:0] pc4);
        check({tag, ".pc"}, bus.pc_o, pc);
        check({tag, ".addr"}, 32'(bus.imem_addr_o), 32'(pc[17:2]));
        check({tag, ".valid"}, 32'(bus.id_valid_o), 32'(valid));
        check({tag, ".inst"}, bus.id_inst_o, inst);
        check({tag, ".pc4"}, bus.id_pc_plus4_o, pc4);
    endtask

    task automatic expect_perf(input string tag, input int f, input int s, input int fl);
`ifdef IF_PERF_CNT_EN
        check({tag, ".perf_fetch"}, bus.perf_fetch_o, 32'(f));
        check({tag, ".perf_stall"}, bus.perf_stall_o, 32'(s));
        check({tag, ".perf_flush"}, bus.perf_flush_o, 32'(fl));
`else
        check({tag, ".perf_fetch"}, bus.perf_fetch_o, 32'(f - f));
        check({tag, ".perf_stall"}, bus.perf_stall_o, 32'(s - s));
        check({tag, ".perf_flush"}, bus.perf_flush_o, 32'(fl - fl));
`endif
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;

        // Reset and boot: PC sits at 0 for two edges, first fetch commits on the third.
        step();
        step();
        rst = 1'b0;
        expect_if("reset", 32'h0, 1'b0, 32'h0, 32'h0);
        expect_perf("reset", 0, 0, 0);
        step();
        expect_if("boot1", 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        expect_if("boot2", 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        expect_if("run1", 32'd4, 1'b1, 32'h0020_1820, 32'd4);
        step();
        expect_if("run2", 32'd8, 1'b1, 32'h8C00_0001, 32'd8);
        step();
        expect_if("run3", 32'd12, 1'b1, 32'h8C00_0002, 32'd12);

        // Three-cycle stall at PC 12, then resume.
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_if("stall", 32'd12, 1'b1, 32'h8C00_0002, 32'd12);
        end
        expect_perf("stall", 3, 3, 0);
        bus.stall_i = 1'b0;
        step();
        expect_if("unstall", 32'd16, 1'b1, 32'h8C00_0003, 32'd16);
        step();
        expect_if("run5", 32'd20, 1'b1, 32'h8C00_0004, 32'd20);
        step();
        expect_if("zero_inst", 32'd24, 1'b1, 32'h0000_0000, 32'd24);
        for (int i = 0; i < 4; i++) step();
        expect_if("at40", 32'd40, 1'b1, 32'h8C00_0009, 32'd40);
        expect_perf("at40", 10, 3, 0);

        // Misaligned redirect target 6 aligns to 4 and flushes IF/ID.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0006;
        step();
        expect_if("redirect", 32'd4, 1'b0, 32'h0, 32'h0);
        expect_perf("redirect", 10, 3, 1);
        bus.redirect_i = 1'b0;
        step();
        expect_if("post_redir", 32'd8, 1'b1, 32'h8C00_0001, 32'd8);

        // Redirect wins over a simultaneous stall.
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0020;
        step();
        expect_if("stall_redir", 32'h20, 1'b0, 32'h0, 32'h0);
        expect_perf("stall_redir", 11, 3, 2);

        // Wrap at the top of the address space.
        bus.stall_i       = 1'b0;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        step();
        expect_if("to_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        bus.redirect_i = 1'b0;
        step();
        expect_if("wrap", 32'h0, 1'b1, 32'h8C00_FFFF, 32'h0);
        step();
        expect_if("after_wrap", 32'd4, 1'b1, 32'h0020_1820, 32'd4);

        // Reset in the middle of a stall at PC 28.
        for (int i = 0; i < 6; i++) step();
        expect_if("at28", 32'd28, 1'b1, 32'h8C00_0006, 32'd28);
        bus.stall_i = 1'b1;
        step();
        expect_if("stall28", 32'd28, 1'b1, 32'h8C00_0006, 32'd28);
        rst = 1'b1;
        step();
        expect_if("mid_reset", 32'h0, 1'b0, 32'h0, 32'h0);
        expect_perf("mid_reset", 0, 0, 0);

        // Boot ignores stall and redirect.
        rst               = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0100;
        step();
        expect_if("boot_ign1", 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        expect_if("boot_ign2", 32'h0, 1'b0, 32'h0, 32'h0);
        expect_perf("boot_ign", 0, 0, 0);
        bus.redirect_i = 1'b0;
        bus.stall_i    = 1'b0;
        step();
        expect_if("reboot_run", 32'd4, 1'b1, 32'h0020_1820, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the PC and the IF/ID pipeline register, and drives the word address into the 64K-word instruction memory. Accepts a stall from the hazard unit and a redirect (branch/jump target) resolved in ID. Feeds the decode stage with instruction, PC+4 and a valid bit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
IMEM_AW, 16, instruction memory word-address width (65536 words)
BOOT_CYCLES, 2, cycles after reset release before the first fetch is committed; range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall_i  input  1  load-use stall from hazard unit: hold PC and IF/ID
redirect_i  input  1  taken branch/jump resolved in ID
redirect_pc_i  input  32  target byte address
imem_addr_o  output  IMEM_AW  word address to instruction memory, equals pc_o[IMEM_AW+1:2]
imem_rdata_i  input  32  combinational instruction word at imem_addr_o
pc_o  output  32  current PC
id_valid_o  output  1  IF/ID holds a real instruction
id_inst_o  output  32  IF/ID instruction; 32'h0 (NOP) when invalid
id_pc_plus4_o  output  32  IF/ID PC+4
perf_fetch_o, perf_stall_o, perf_flush_o  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge): pc_o=RESET_PC, id_valid_o=0, id_inst_o=0, id_pc_plus4_o=0, FSM=BOOT, boot counter=0, perf counters=0. Reset overrides all other inputs, including mid-stall and mid-redirect.
- FSM:
  - BOOT: PC holds, IF/ID stays NOP/invalid, stall_i and redirect_i are ignored. Counter increments each cycle; on reaching BOOT_CYCLES-1, the FSM moves to RUN.
  - RUN: the only other state; RUN is left only by reset.
- RUN priority per edge: redirect > stall > advance.
  - redirect_i=1: PC <= {redirect_pc_i[31:2],2'b00} (misaligned targets are silently aligned). IF/ID is flushed to NOP: valid=0, inst=0, pc_plus4=0. This applies even if stall_i=1.
  - stall_i=1 (no redirect): PC and IF/ID hold all values.
  - Otherwise: PC <= PC+4. IF/ID <= {imem_rdata_i, PC+4}, valid=1.
- Latency: an instruction at PC appears on id_inst_o one edge after it is addressed. The first valid instruction appears BOOT_CYCLES+1 edges after reset release.
- Arithmetic: PC+4 is modulo 2^32 (32'hFFFF_FFFC -> 0). imem_addr_o wraps naturally at 2^IMEM_AW words. No exceptions are raised.
- The all-zero instruction is a NOP. It is still flagged valid=1 when fetched from memory; only flush/reset/boot bubbles have valid=0.
- imem_addr_o is combinational from the PC register only; there is no path from stall_i or redirect_i.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, cleared by reset, counting only in RUN:
  - perf_fetch_o increments on each advance.
  - perf_stall_o increments on each stall-hold cycle.
  - perf_flush_o increments on each redirect.
- Undefined: the counters are absent and the three outputs are tied to 32'h0. All other behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg: WORD_W=32, NOP_INST=32'h0, the fetch FSM enum (FS_BOOT, FS_RUN), and an if_id_t struct {valid, inst, pc_plus4} reused by the ID stage.
- One natural sub-module, if_id_reg: the IF/ID register with hold/flush/load controls. The PC, the FSM and the counters stay in if_stage.

Test Plan:
- Boot: assert rst for 2 edges, release; with BOOT_CYCLES=2, pc_o=0 for 2 cycles, then 4, 8. id_valid_o first rises 3 edges after release with id_inst_o=mem[0]=32'h0020_1820 and id_pc_plus4_o=4.
- Stall: in RUN at pc_o=12, assert stall_i for 3 cycles -> pc_o stays 12 and IF/ID is unchanged. On release, next edge gives pc_o=16 and id_inst_o=mem[3].
- Redirect: at pc_o=40, redirect_i=1, redirect_pc_i=32'h0000_0006 -> next pc_o=4, id_valid_o=0, id_inst_o=0. The edge after gives id_inst_o=mem[1]. With IF_PERF_CNT_EN, perf_flush_o=1.
- Simultaneous: stall_i=1 and redirect_i=1 with redirect_pc_i=32'h20 -> redirect wins: pc_o=32'h20, IF/ID flushed, perf_stall_o unchanged.
- Wrap: redirect to 32'hFFFF_FFFC -> imem_addr_o=16'hFFFF. The next advance gives pc_o=0, imem_addr_o=0 and id_pc_plus4_o=0.
- Mid-operation reset: rst=1 during a stall at pc_o=28 -> next edge pc_o=0, IF/ID NOP/invalid, FSM in BOOT, counters 0.
